// File: rtl/tdm_demux16.sv
// Receive side of a 16-slot TDM link: a hunt/lock FSM tracks frame alignment
// and a slot counter steers beats into a shadow frame that commits atomically to q.
module tdm_demux16 #(
  parameter int WIDTH       = 1,
  parameter bit STRICT_SYNC = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  input  logic                  sync,
  output logic [16*WIDTH-1:0]   q,
  output logic [3:0]            slot,
  output logic                  frame_done,
  output logic                  locked,
  output logic                  sync_err
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [15:0][WIDTH-1:0]   shadow;
  logic [3:0]               slot_nxt;
  logic [3:0]               wr_idx;
  logic                     wr_en;
  logic                     commit;
  logic                     err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  // The last beat of a frame goes straight from din into q, bypassing shadow[15].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      slot       <= 4'd0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      shadow     <= '0;
    end else begin
      slot       <= slot_nxt;
      frame_done <= commit;
      sync_err   <= err_nxt;
      if (wr_en)  shadow[wr_idx] <= din;
      if (commit) q <= {din, shadow[14:0]};
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    wr_idx    = slot;
    wr_en     = 1'b0;
    commit    = 1'b0;
    err_nxt   = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (sync) begin
            wr_en     = 1'b1;
            wr_idx    = 4'd0;
            slot_nxt  = 4'd1;
            state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (sync) begin
            // A sync beat always restarts the frame; mid-frame it is an alignment error.
            err_nxt  = (slot != 4'd0);
            wr_en    = 1'b1;
            wr_idx   = 4'd0;
            slot_nxt = 4'd1;
          end else if (slot == 4'd0) begin
            if (STRICT_SYNC) begin
              err_nxt   = 1'b1;
              slot_nxt  = 4'd0;
              state_nxt = HUNT;
            end else begin
              wr_en    = 1'b1;
              wr_idx   = 4'd0;
              slot_nxt = 4'd1;
            end
          end else begin
            wr_en    = 1'b1;
            slot_nxt = slot + 4'd1;
            commit   = (slot == 4'd15);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux16.sv
// Scoreboard bench for tdm_demux16: a WIDTH=1 strict instance and a WIDTH=4
// tolerant instance share clock and reset; a negedge monitor does all comparisons.
module tb_tdm_demux16;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din1, din_valid1, sync1;
  logic [15:0] q1;
  logic [3:0]  slot1;
  logic        frame_done1, locked1, sync_err1;
  logic [3:0]  din4;
  logic        din_valid4, sync4;
  logic [63:0] q4;
  logic [3:0]  slot4;
  logic        frame_done4, locked4, sync_err4;

  chk_t        pend[$];
  logic [15:0] exp_q1[$];
  logic [63:0] exp_q4[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt1 = 0, err_cnt1 = 0, done_cnt4 = 0, err_cnt4 = 0;

  always #5 clk = ~clk;

  tdm_demux16 #(.WIDTH(1), .STRICT_SYNC(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(din_valid1), .sync(sync1),
    .q(q1), .slot(slot1), .frame_done(frame_done1), .locked(locked1), .sync_err(sync_err1)
  );

  tdm_demux16 #(.WIDTH(4), .STRICT_SYNC(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(din_valid4), .sync(sync4),
    .q(q4), .slot(slot4), .frame_done(frame_done4), .locked(locked4), .sync_err(sync_err4)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sole owner of the counters: drains queued direct checks and scores every committed frame.
  always @(negedge clk) begin
    while (pend.size() > 0) begin
      chk_t c;
      c = pend.pop_front();
      cmp(c.name, c.act, c.exp);
    end
    if (frame_done1) begin
      done_cnt1++;
      if (exp_q1.size() == 0) cmp("q1_unexpected_frame", 64'(q1), 64'hx);
      else                    cmp("q1_frame", 64'(q1), 64'(exp_q1.pop_front()));
      cmp("done_err_excl1", 64'(sync_err1), 64'd0);
    end
    if (sync_err1) err_cnt1++;
    if (frame_done4) begin
      done_cnt4++;
      if (exp_q4.size() == 0) cmp("q4_unexpected_frame", q4, 64'hx);
      else                    cmp("q4_frame", q4, exp_q4.pop_front());
    end
    if (sync_err4) err_cnt4++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    pend.push_back('{name, act, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat1(input logic d, input logic s);
    din1 = d; sync1 = s; din_valid1 = 1'b1;
    @(negedge clk);
    din_valid1 = 1'b0; sync1 = 1'b0;
  endtask

  task automatic send_beat4(input logic [3:0] d, input logic s);
    din4 = d; sync4 = s; din_valid4 = 1'b1;
    @(negedge clk);
    din_valid4 = 1'b0; sync4 = 1'b0;
  endtask

  // Lane i of v travels in beat i; sync rides on beat 0 only.
  task automatic send_frame1(input logic [15:0] v, input bit gaps, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      send_beat1(v[i], i == 0);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  task automatic send_frame4(input logic [63:0] v, input bit with_sync);
    for (int i = 0; i < 16; i++) send_beat4(v[i*4 +: 4], with_sync && (i == 0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] c;
    rst_n = 1'b0;
    din1 = 1'b0; din_valid1 = 1'b0; sync1 = 1'b0;
    din4 = 4'h0; din_valid4 = 1'b0; sync4 = 1'b0;
    idle(2);
    check("rst_q1", 64'(q1), 64'd0);
    check("rst_slot1", 64'(slot1), 64'd0);
    check("rst_locked1", 64'(locked1), 64'd0);
    check("rst_done1", 64'(frame_done1), 64'd0);
    check("rst_err1", 64'(sync_err1), 64'd0);
    rst_n = 1'b1;
    idle(1);

    $display("[TB] hunt ignores beats without sync");
    send_beat1(1'b1, 1'b0);
    send_beat1(1'b1, 1'b0);
    check("hunt_slot", 64'(slot1), 64'd0);
    check("hunt_locked", 64'(locked1), 64'd0);

    $display("[TB] first frame 8111");
    exp_q1.push_back(16'h8111);
    send_frame1(16'h8111, 1'b0, 0, 15);
    check("t1_locked", 64'(locked1), 64'd1);
    check("t1_slot_wrap", 64'(slot1), 64'd0);
    check("t1_done_pulse", 64'(frame_done1), 64'd1);
    idle(1);
    check("t1_done_cleared", 64'(frame_done1), 64'd0);

    $display("[TB] frames 00FF then A5A5 with gaps");
    exp_q1.push_back(16'h00FF);
    send_frame1(16'h00FF, 1'b0, 0, 15);
    exp_q1.push_back(16'hA5A5);
    send_frame1(16'hA5A5, 1'b1, 0, 14);
    check("t2_q_held_mid_frame", 64'(q1), 64'h00FF);
    check("t2_slot15", 64'(slot1), 64'd15);
    send_frame1(16'hA5A5, 1'b1, 15, 15);
    idle(1);
    check("t2_q_after", 64'(q1), 64'hA5A5);

    $display("[TB] early sync on beat 7");
    send_frame1(16'h0055, 1'b0, 0, 6);
    c = 16'h3C96;
    exp_q1.push_back(c);
    send_beat1(c[0], 1'b1);
    check("t3_err_pulse", 64'(sync_err1), 64'd1);
    check("t3_q_kept", 64'(q1), 64'hA5A5);
    check("t3_slot1", 64'(slot1), 64'd1);
    check("t3_locked", 64'(locked1), 64'd1);
    idle(1);
    check("t3_err_idle_low", 64'(sync_err1), 64'd0);
    send_frame1(c, 1'b0, 1, 15);

    $display("[TB] missing sync under strict mode");
    send_beat1(1'b1, 1'b0);
    check("t4_err_pulse", 64'(sync_err1), 64'd1);
    check("t4_unlocked", 64'(locked1), 64'd0);
    check("t4_q_kept", 64'(q1), 64'h3C96);
    send_beat1(1'b1, 1'b0);
    send_beat1(1'b0, 1'b0);
    check("t4_hunt_slot", 64'(slot1), 64'd0);
    check("t4_hunt_locked", 64'(locked1), 64'd0);
    exp_q1.push_back(16'h1234);
    send_frame1(16'h1234, 1'b0, 0, 15);
    check("t4_relocked", 64'(locked1), 64'd1);

    $display("[TB] WIDTH=4 lanes, tolerant sync");
    exp_q4.push_back(64'hFEDCBA9876543210);
    send_frame4(64'hFEDCBA9876543210, 1'b1);
    check("t5_q4", q4, 64'hFEDCBA9876543210);
    exp_q4.push_back(64'h0123456789ABCDEF);
    send_frame4(64'h0123456789ABCDEF, 1'b0);
    check("t5_q4_nosync", q4, 64'h0123456789ABCDEF);
    check("t5_locked4", 64'(locked4), 64'd1);

    $display("[TB] reset after beat 9");
    send_frame1(16'hFFFF, 1'b0, 0, 9);
    #2 rst_n = 1'b0;
    #1;
    check("t6_q1_async", 64'(q1), 64'd0);
    check("t6_slot1_async", 64'(slot1), 64'd0);
    check("t6_locked1_async", 64'(locked1), 64'd0);
    check("t6_q4_async", q4, 64'd0);
    @(negedge clk);
    send_beat1(1'b1, 1'b1);
    check("t6_no_sample_in_reset", 64'(locked1), 64'd0);
    rst_n = 1'b1;
    send_beat1(1'b1, 1'b0);
    send_beat1(1'b1, 1'b0);
    check("t6_slot_after_release", 64'(slot1), 64'd0);
    check("t6_locked_after_release", 64'(locked1), 64'd0);
    exp_q1.push_back(16'hBEEF);
    send_frame1(16'hBEEF, 1'b1, 0, 15);
    idle(1);
    check("t6_q_new_frame", 64'(q1), 64'hBEEF);

    idle(2);
    check("frames_seen1", 64'(done_cnt1), 64'd6);
    check("errors_seen1", 64'(err_cnt1), 64'd2);
    check("frames_seen4", 64'(done_cnt4), 64'd2);
    check("errors_seen4", 64'(err_cnt4), 64'd0);
    check("pending_frames1", 64'(exp_q1.size()), 64'd0);
    check("pending_frames4", 64'(exp_q4.size()), 64'd0);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
